even_seq_checker: RTL

Downstream consumer of the 4-bit even-number generator. Samples the generator's ripple-clocked count on the system clock, filters ripple glitches, and confirms that each settled value is even and exactly one step above the previous one (mod 16). It republishes each accepted value with a one-cycle strobe and keeps saturating wrap and error counters for status readout.

---
 rtl/even_seq_checker.sv | 82 ++++++++
 1 files changed

// File: rtl/even_seq_checker.sv
// even_seq_checker: settles the generator's count and checks each value is even and one STEP above the last
module even_seq_checker #(
  parameter int STABLE_CYC = 2,
  parameter int STEP       = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       num_in,
  output logic             valid,
  output logic [3:0]       value,
  output logic             locked,
  output logic             odd_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t     state;
  logic [3:0] s1, s2, cand, stab, last, nxt;
  logic       done, settle;
  assign nxt    = last + 4'(STEP);
  assign locked = state == LOCKED;
  // done marks that the current candidate has already produced its single event
  assign settle = stab == 4'(STABLE_CYC) && !done && (cand != last || state == UNLOCKED);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      stab <= '0;
      done <= 1'b0;
    end else begin
      s1 <= num_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        stab <= 4'd1;
        done <= 1'b0;
      end else begin
        if (stab < 4'(STABLE_CYC)) stab <= stab + 4'd1;
        if (stab == 4'(STABLE_CYC)) done <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= UNLOCKED;
      last     <= '0;
      value    <= '0;
      valid    <= 1'b0;
      odd_err  <= 1'b0;
      seq_err  <= 1'b0;
      wrap_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      valid   <= 1'b0;
      odd_err <= 1'b0;
      seq_err <= 1'b0;
      if (!en) begin
        state <= UNLOCKED;
      end else if (settle) begin
        if (cand[0]) begin
          odd_err <= 1'b1;
          state   <= UNLOCKED;
          if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
        end else begin
          last  <= cand;
          value <= cand;
          valid <= 1'b1;
          state <= LOCKED;
          if (state == LOCKED && cand == nxt && cand < last && ~&wrap_cnt) wrap_cnt <= wrap_cnt + 1'b1;
          if (state == LOCKED && cand != nxt) begin
            seq_err <= 1'b1;
            if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule
